// File: rtl/tx_serial_pkg.sv
// Shared types and line-level constants for the FIFO-fed serial transmitter.
package tx_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;
    localparam int   DATA_BITS = 8;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/fifo_serial_tx_baud_timer.sv
// Bit-period counter: counts 0..BIT_PERIOD-1 while enabled and flags the last cycle of each bit.
module baud_timer #(
    parameter int BIT_PERIOD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic bit_tick
);

    localparam logic [7:0] LAST_COUNT = 8'(BIT_PERIOD - 1);

    logic [7:0] count;

    assign bit_tick = count_en && (count == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= bit_tick ? 8'd0 : count + 8'd1;
        end
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// Drains a first-word-fall-through FIFO and shifts each byte out as an
// async frame: start, 8 data bits LSB-first, optional even parity, stop.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line high, waiting for tx_enable with a non-empty FIFO
// ST_START  | driving the start bit (low) for one bit period
// ST_DATA   | driving shift[0]; shift right and advance bit index per bit
// ST_PARITY | driving the latched even-parity bit (only when PARITY_EN)
// ST_STOP   | driving the stop bit; last cycle may pop the next byte
module fifo_serial_tx
    import tx_serial_pkg::*;
#(
    parameter int BIT_PERIOD = 10,
    parameter bit PARITY_EN  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_enable,
    input  logic       fifo_empty,
    input  logic [7:0] read_data,
    output logic       read_enable,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       frame_done
);

    tx_state_t  state;
    tx_state_t  state_nxt;
    logic [7:0] shift;
    logic [7:0] shift_nxt;
    logic       parity;
    logic       parity_nxt;
    logic [2:0] bit_idx;
    logic [2:0] bit_idx_nxt;
    logic       line_nxt;
    logic       can_pop;
    logic       pop;
    logic       bit_tick;

    baud_timer #(
        .BIT_PERIOD(BIT_PERIOD)
    ) u_baud_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (pop),
        .count_en (state != ST_IDLE),
        .bit_tick (bit_tick)
    );

    // Reset wins over a simultaneous pop condition.
    assign can_pop = tx_enable && !fifo_empty && !rst;

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        parity_nxt  = parity;
        bit_idx_nxt = bit_idx;
        pop         = 1'b0;
        frame_done  = 1'b0;
        line_nxt    = IDLE_LVL;

        unique case (state)
            ST_IDLE: begin
                if (can_pop) begin
                    pop = 1'b1;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_nxt   = {1'b0, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    frame_done = !rst;
                    if (can_pop) begin
                        pop = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (pop) begin
            shift_nxt   = read_data;
            parity_nxt  = even_parity(read_data);
            bit_idx_nxt = '0;
            state_nxt   = ST_START;
        end

        // serial_out is registered, so it follows the level of the state being entered.
        unique case (state_nxt)
            ST_START:  line_nxt = START_LVL;
            ST_DATA:   line_nxt = shift_nxt[0];
            ST_PARITY: line_nxt = parity_nxt;
            ST_STOP:   line_nxt = STOP_LVL;
            default:   line_nxt = IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shift      <= '0;
            parity     <= 1'b0;
            bit_idx    <= '0;
            serial_out <= IDLE_LVL;
        end else begin
            state      <= state_nxt;
            shift      <= shift_nxt;
            parity     <= parity_nxt;
            bit_idx    <= bit_idx_nxt;
            serial_out <= line_nxt;
        end
    end

    assign read_enable = pop;
    assign tx_busy     = (state != ST_IDLE);

endmodule
